// File: rtl/pulse_gen_pkg.sv
// Shared types and default sizes for the trigger-to-pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int DEF_W = 8;
    localparam int DEF_D = 8;

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable saturating down-counter; tc marks the last counted cycle (count == 1).
module pulse_down_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dec,
    output logic         tc,
    output logic         zero
);

    logic [N-1:0] count;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc   = (count == N'(1));
    assign zero = (count == '0);

endmodule

// File: rtl/pulse_generator.sv
// Converts a single-cycle trigger into a delayed, fixed-width, optionally retriggerable pulse.
module pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         trig,
    input  logic [D-1:0] delay,
    input  logic [W-1:0] width,
    input  logic         retrig_en,
    output logic         out,
    output logic         busy,
    output logic         done
);

    // Handshake: trig is a one-cycle strobe with no ready; it is taken only in IDLE,
    // or in ACTIVE when retrig_en=1. done is a one-cycle completion strobe.
    state_t state;
    logic   accept, retrig;
    logic   d_tc, d_zero, w_tc, w_zero;

    assign accept = (state == IDLE) && trig;
    assign retrig = (state == ACTIVE) && trig && retrig_en;

    pulse_down_counter #(.N(D)) u_delay_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (delay),
        .dec      (state == DELAY),
        .tc       (d_tc),
        .zero     (d_zero)
    );

    // The width counter doubles as the latched width while the delay runs.
    pulse_down_counter #(.N(W)) u_width_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept || retrig),
        .load_val (width),
        .dec      (state == ACTIVE),
        .tc       (w_tc),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        if (delay != '0) begin
                            state <= DELAY;
                            busy  <= 1'b1;
                        end else if (width != '0) begin
                            state <= ACTIVE;
                            busy  <= 1'b1;
                            out   <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (d_tc || d_zero) begin
                        if (!w_zero) begin
                            state <= ACTIVE;
                            out   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    // A retrigger in the final cycle still extends the pulse.
                    if ((retrig && (width == '0)) || (!retrig && w_tc)) begin
                        state <= IDLE;
                        out   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator: per-cycle waveform checks against hand-derived windows.
module tb_pulse_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trig = 1'b0;
    logic [7:0] delay = '0;
    logic [7:0] width = '0;
    logic       retrig_en = 1'b0;
    logic       out, busy, done;

    int total = 0;
    int bad = 0;

    logic       rec_out  [0:599];
    logic       rec_busy [0:599];
    logic       rec_done [0:599];
    logic       trig_at  [0:599];
    logic [7:0] dly_at   [0:599];
    logic [7:0] wid_at   [0:599];
    logic       e_out, e_busy, e_done;

    pulse_generator #(.W(8), .D(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .delay     (delay),
        .width     (width),
        .retrig_en (retrig_en),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic set_const(input logic [7:0] d, input logic [7:0] w);
        for (int k = 0; k < 600; k++) begin
            trig_at[k] = 1'b0;
            dly_at[k]  = d;
            wid_at[k]  = w;
        end
    endtask

    // Cycle k runs between rising edges k and k+1; outputs are sampled at its falling edge
    // and the inputs for that cycle are driven right after.
    task automatic run_seq(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rec_out[k]  = out;
            rec_busy[k] = busy;
            rec_done[k] = done;
            trig  = trig_at[k];
            delay = dly_at[k];
            width = wid_at[k];
        end
        @(negedge clk);
        trig = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        total += 3;
        if (out !== 1'b0)  begin bad++; $display("FAIL reset_out got=%b exp=0", out); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        repeat (2) @(negedge clk);
        // First trigger in the very cycle reset is released.
        rst = 1'b0; trig = 1'b1; delay = 8'd0; width = 8'd1;
        @(negedge clk);
        trig = 1'b0;
        total += 2;
        if (out !== 1'b1)  begin bad++; $display("FAIL first_trig_out got=%b exp=1", out); end
        if (busy !== 1'b1) begin bad++; $display("FAIL first_trig_busy got=%b exp=1", busy); end
        @(negedge clk);
        total += 2;
        if (out !== 1'b0)  begin bad++; $display("FAIL first_trig_out_end got=%b exp=0", out); end
        if (done !== 1'b1) begin bad++; $display("FAIL first_trig_done got=%b exp=1", done); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        trig = 1'b1; delay = 8'd0; width = 8'd10;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            trig = 1'b0;
            total++;
            if (out !== 1'b1) begin bad++; $display("FAIL mid_pre_out cyc=%0d got=%b exp=1", k, out); end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total += 3;
        if (out !== 1'b0)  begin bad++; $display("FAIL mid_rst_out got=%b exp=0", out); end
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b exp=0", done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            total += 2;
            if (done !== 1'b0) begin bad++; $display("FAIL mid_post_done cyc=%0d got=%b exp=0", k, done); end
            if (busy !== 1'b0) begin bad++; $display("FAIL mid_post_busy cyc=%0d got=%b exp=0", k, busy); end
        end
    endtask

    task automatic test_basic;
        set_const(8'd7, 8'd1);
        dly_at[0] = 8'd3; wid_at[0] = 8'd5; trig_at[0] = 1'b1;
        run_seq(14);
        for (int k = 0; k < 14; k++) begin
            e_out = (k >= 4 && k <= 8); e_busy = (k >= 1 && k <= 8); e_done = (k == 9);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL basic_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
    endtask

    task automatic test_zero;
        set_const(8'd0, 8'd1);
        trig_at[0] = 1'b1;
        run_seq(6);
        for (int k = 0; k < 6; k++) begin
            e_out = (k == 1); e_busy = (k == 1); e_done = (k == 2);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL z01_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL z01_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL z01_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
        set_const(8'd2, 8'd0);
        trig_at[0] = 1'b1;
        run_seq(7);
        for (int k = 0; k < 7; k++) begin
            e_out = 1'b0; e_busy = (k >= 1 && k <= 2); e_done = (k == 3);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL z20_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL z20_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL z20_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
        set_const(8'd0, 8'd0);
        trig_at[0] = 1'b1;
        run_seq(5);
        for (int k = 0; k < 5; k++) begin
            e_out = 1'b0; e_busy = 1'b0; e_done = (k == 1);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL z00_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL z00_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL z00_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
    endtask

    task automatic test_retrigger;
        retrig_en = 1'b1;
        set_const(8'd0, 8'd4);
        trig_at[0] = 1'b1; trig_at[3] = 1'b1;
        run_seq(12);
        for (int k = 0; k < 12; k++) begin
            e_out = (k >= 1 && k <= 7); e_busy = e_out; e_done = (k == 8);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL retrig_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL retrig_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL retrig_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
        // Retrigger with width 0 cuts the pulse short.
        set_const(8'd0, 8'd4);
        trig_at[0] = 1'b1; trig_at[2] = 1'b1; wid_at[2] = 8'd0;
        run_seq(9);
        for (int k = 0; k < 9; k++) begin
            e_out = (k >= 1 && k <= 2); e_busy = e_out; e_done = (k == 3);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL retrig0_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL retrig0_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL retrig0_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
        retrig_en = 1'b0;
        set_const(8'd0, 8'd4);
        trig_at[0] = 1'b1; trig_at[3] = 1'b1;
        run_seq(10);
        for (int k = 0; k < 10; k++) begin
            e_out = (k >= 1 && k <= 4); e_busy = e_out; e_done = (k == 5);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL noretrig_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL noretrig_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL noretrig_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
    endtask

    task automatic test_back_to_back;
        retrig_en = 1'b1;
        set_const(8'd0, 8'd2);
        trig_at[0] = 1'b1; trig_at[3] = 1'b1;
        run_seq(10);
        for (int k = 0; k < 10; k++) begin
            e_out = (k >= 1 && k <= 2) || (k >= 4 && k <= 5); e_busy = e_out; e_done = (k == 3) || (k == 6);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL b2b_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
        set_const(8'd5, 8'd1);
        trig_at[0] = 1'b1; trig_at[2] = 1'b1;
        run_seq(12);
        for (int k = 0; k < 12; k++) begin
            e_out = (k == 6); e_busy = (k >= 1 && k <= 6); e_done = (k == 7);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL dlyign_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL dlyign_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL dlyign_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
        retrig_en = 1'b0;
    endtask

    task automatic test_max;
        set_const(8'd255, 8'd255);
        trig_at[0] = 1'b1;
        run_seq(520);
        for (int k = 0; k < 520; k++) begin
            e_out = (k >= 256 && k <= 510); e_busy = (k >= 1 && k <= 510); e_done = (k == 511);
            total += 3;
            if (rec_out[k] !== e_out)   begin bad++; $display("FAIL max_out cyc=%0d got=%b exp=%b", k, rec_out[k], e_out); end
            if (rec_busy[k] !== e_busy) begin bad++; $display("FAIL max_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
            if (rec_done[k] !== e_done) begin bad++; $display("FAIL max_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid;
        test_basic;
        test_zero;
        test_retrigger;
        test_back_to_back;
        test_max;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
